// File: rtl/decimator.sv
// rtl/decimator.sv - Power-of-ten boxcar decimator for a 12-bit offset-binary ADC stream
//
// Averages N = 10^Mode consecutive samples (Mode 5..15 behaves as 4) and
// publishes the mean as a signed 12-bit value in bits [29:18] of out_new.
//
// Ports:
//   Fg_CLK   in   1  system clock, rising edge
//   RESETn   in   1  asynchronous active-low reset
//   adc_in   in  12  converter sample, offset binary (12'h800 = 0)
//   Mode     in   4  decimation exponent, latched at the first sample of a frame
//   Enable   in   1  run control; low discards the partial frame and idles
//   Sync     in   1  restart the frame with the current sample as sample 0
//   out_new  out 32  newest decimated sample
//   out_prev out 32  previous decimated sample
//   Valid    out  1  one-cycle pulse when out_new/out_prev update
module decimator (
  input  logic        Fg_CLK,
  input  logic        RESETn,
  input  logic [11:0] adc_in,
  input  logic [3:0]  Mode,
  input  logic        Enable,
  input  logic        Sync,
  output logic [31:0] out_new,
  output logic [31:0] out_prev,
  output logic        Valid
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic               state;
  logic signed [25:0] acc;
  logic signed [25:0] acc_base;
  logic signed [25:0] x;
  logic signed [25:0] sum_reg;
  logic [13:0]        cnt;
  logic [13:0]        cnt_base;
  logic [2:0]         mode_lat;
  logic [2:0]         mode_clamp;
  logic [2:0]         mode_eff;
  logic [2:0]         sum_mode;
  logic               restart;
  logic               frame_start;
  logic               last;
  logic               sum_v;
  logic               prod_v;
  logic [31:0]        r_sel;
  logic [56:0]        mult_full;
  logic signed [56:0] product;

  function automatic logic [13:0] last_index(input logic [2:0] m);
    case (m)
      3'd0:    last_index = 14'd0;
      3'd1:    last_index = 14'd9;
      3'd2:    last_index = 14'd99;
      3'd3:    last_index = 14'd999;
      default: last_index = 14'd9999;
    endcase
  endfunction

  always_comb begin
    // Offset binary to two's complement is a flip of the MSB.
    x          = {{14{~adc_in[11]}}, ~adc_in[11], adc_in[10:0]};
    mode_clamp = (Mode > 4'd4) ? 3'd4 : Mode[2:0];
    // Sync makes this edge look like sample 0 of a fresh frame.
    restart    = (state == RUN) && Sync;
    cnt_base   = restart ? 14'd0 : cnt;
    acc_base   = restart ? 26'sd0 : acc;
    // The first sample of a frame must already obey the Mode being latched.
    frame_start = (cnt_base == 14'd0);
    mode_eff    = frame_start ? mode_clamp : mode_lat;
    last        = (cnt_base == last_index(mode_eff));
    case (sum_mode)
      3'd1:    r_sel = 32'd1717986918;
      3'd2:    r_sel = 32'd171798692;
      3'd3:    r_sel = 32'd17179869;
      default: r_sel = 32'd1717987;
    endcase
    // Low 57 bits of the two's-complement product are exact for any sign.
    mult_full = {{31{sum_reg[25]}}, sum_reg} * {25'd0, r_sel};
  end

  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      mode_lat <= '0;
      sum_reg  <= '0;
      sum_mode <= '0;
      sum_v    <= 1'b0;
      product  <= '0;
      prod_v   <= 1'b0;
      out_new  <= '0;
      out_prev <= '0;
      Valid    <= 1'b0;
    end else begin
      state <= Enable ? RUN : IDLE;
      sum_v <= 1'b0;
      if (Enable) begin
        if (frame_start) mode_lat <= mode_clamp;
        if (last) begin
          sum_reg  <= acc_base + x;
          sum_mode <= mode_eff;
          sum_v    <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= acc_base + x;
          cnt <= cnt_base + 14'd1;
        end
      end else begin
        acc <= '0;
        cnt <= '0;
      end

      // Frames already past the accumulator finish regardless of Enable/Sync.
      prod_v <= sum_v;
      if (sum_v) begin
        // Mode 0 is pre-shifted so the common >>>16 yields sum << 18.
        if (sum_mode == 3'd0) product <= {sum_reg[22:0], 34'd0};
        else                  product <= mult_full;
      end

      Valid <= prod_v;
      if (prod_v) begin
        out_new  <= 32'(product >>> 16);
        out_prev <= out_new;
      end
    end
  end

endmodule

// File: tb/tb_decimator.sv
// tb/tb_decimator.sv - Self-checking bench for decimator against a frame-level model
module tb_decimator;

  logic        Fg_CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [11:0] adc_in = 12'h800;
  logic [3:0]  Mode   = 4'd0;
  logic        Enable = 1'b0;
  logic        Sync   = 1'b0;
  logic [31:0] out_new;
  logic [31:0] out_prev;
  logic        Valid;

  decimator dut (
    .Fg_CLK  (Fg_CLK),
    .RESETn  (RESETn),
    .adc_in  (adc_in),
    .Mode    (Mode),
    .Enable  (Enable),
    .Sync    (Sync),
    .out_new (out_new),
    .out_prev(out_prev),
    .Valid   (Valid)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] val;
  } res_t;

  res_t        pend[$];
  int          cyc = 0;
  bit          in_run = 0;
  int          fr_cnt = 0;
  int          fr_mode = 0;
  longint      fr_sum = 0;
  logic        exp_v = 1'b0;
  logic [31:0] exp_new = '0;
  logic [31:0] exp_prev = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic int frame_len(input int m);
    int n = 1;
    for (int i = 0; i < m; i++) n = n * 10;
    return n;
  endfunction

  function automatic logic [31:0] frame_result(input longint sum, input int m);
    longint coef;
    if (m == 0) return 32'(sum * 262144);
    case (m)
      1:       coef = 1717986918;
      2:       coef = 171798692;
      3:       coef = 17179869;
      default: coef = 1717987;
    endcase
    return 32'((sum * coef) >>> 16);
  endfunction

  task automatic model_clear();
    pend.delete();
    in_run   = 0;
    fr_cnt   = 0;
    fr_sum   = 0;
    fr_mode  = 0;
    exp_v    = 1'b0;
    exp_new  = '0;
    exp_prev = '0;
  endtask

  // Drive one cycle, advance the model on the rising edge, compare on the falling edge.
  task automatic step(input logic [11:0] a, input logic [3:0] m, input logic e, input logic s);
    adc_in = a;
    Mode   = m;
    Enable = e;
    Sync   = s;
    @(posedge Fg_CLK);
    cyc++;
    if (!RESETn) begin
      model_clear();
    end else begin
      if (!e) begin
        fr_cnt = 0;
        fr_sum = 0;
        in_run = 0;
      end else begin
        if (fr_cnt == 0 || (s && in_run)) begin
          fr_cnt  = 0;
          fr_sum  = 0;
          fr_mode = (m > 4) ? 4 : int'(m);
        end
        fr_sum = fr_sum + longint'(int'(a) - 2048);
        fr_cnt++;
        if (fr_cnt == frame_len(fr_mode)) begin
          pend.push_back('{due: cyc + 2, val: frame_result(fr_sum, fr_mode)});
          fr_cnt = 0;
          fr_sum = 0;
        end
        in_run = 1;
      end
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_v    = 1'b1;
        exp_prev = exp_new;
        exp_new  = pend[0].val;
        void'(pend.pop_front());
      end
    end
    @(negedge Fg_CLK);
    chk("valid", {31'd0, Valid}, {31'd0, exp_v});
    chk("out_new", out_new, exp_new);
    chk("out_prev", out_prev, exp_prev);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(12'h800, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int hold);
    #2 RESETn = 1'b0;
    #1;
    chk("rst_async_out_new", out_new, 32'd0);
    chk("rst_async_out_prev", out_prev, 32'd0);
    chk("rst_async_valid", {31'd0, Valid}, 32'd0);
    model_clear();
    for (int i = 0; i < hold; i++) step(12'hFFF, 4'd1, 1'b1, 1'b0);
    RESETn = 1'b1;
  endtask

  initial begin
    int vcount;
    #1;
    chk("reset_out_new", out_new, 32'd0);
    chk("reset_out_prev", out_prev, 32'd0);
    chk("reset_valid", {31'd0, Valid}, 32'd0);
    step(12'h800, 4'd0, 1'b1, 1'b0);
    step(12'h800, 4'd0, 1'b1, 1'b0);
    RESETn = 1'b1;

    // Mode 0: one result per sample, latency 2.
    step(12'h800, 4'd0, 1'b1, 1'b0);
    step(12'hFFF, 4'd0, 1'b1, 1'b0);
    step(12'hFFF, 4'd0, 1'b1, 1'b0);
    chk("m0_first_valid", {31'd0, Valid}, 32'd1);
    chk("m0_first_new", out_new, 32'h00000000);
    step(12'hFFF, 4'd0, 1'b1, 1'b0);
    chk("m0_second_new", out_new, 32'h1FFC0000);
    chk("m0_second_prev", out_prev, 32'h00000000);
    idle(3);

    // Mode 1: floor truncation at both extremes.
    for (int i = 0; i < 10; i++) step(12'h000, 4'd1, 1'b1, 1'b0);
    step(12'hFFF, 4'd1, 1'b1, 1'b0);
    step(12'hFFF, 4'd1, 1'b1, 1'b0);
    chk("m1_min_valid", {31'd0, Valid}, 32'd1);
    chk("m1_min_new", out_new, 32'hE0000000);
    for (int i = 0; i < 8; i++) step(12'hFFF, 4'd1, 1'b1, 1'b0);
    step(12'h800, 4'd1, 1'b0, 1'b0);
    step(12'h800, 4'd1, 1'b0, 1'b0);
    chk("m1_max_new", out_new, 32'h1FFBFFFF);
    chk("m1_max_prev", out_prev, 32'hE0000000);
    idle(3);

    // Mode switched mid-frame only takes effect on the following frame.
    for (int i = 0; i < 5; i++) step(12'($urandom_range(0, 4095)), 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(12'($urandom_range(0, 4095)), 4'd2, 1'b1, 1'b0);
    chk("mode_switch_old_frame", {31'd0, Valid}, 32'd1);
    vcount = 0;
    for (int i = 0; i < 99; i++) begin
      step(12'($urandom_range(0, 4095)), 4'd2, 1'b1, 1'b0);
      vcount += int'(Valid);
    end
    chk("mode_switch_gap", 32'(vcount), 32'd0);
    step(12'($urandom_range(0, 4095)), 4'd2, 1'b1, 1'b0);
    chk("mode_switch_new_frame", {31'd0, Valid}, 32'd1);
    idle(3);

    // Sync at sample 6 drops the partial frame and restarts there.
    for (int i = 0; i < 6; i++) step(12'hA00, 4'd1, 1'b1, 1'b0);
    vcount = 0;
    step(12'h700, 4'd1, 1'b1, 1'b1);
    vcount += int'(Valid);
    for (int i = 0; i < 10; i++) begin
      step(12'h700, 4'd1, 1'b1, 1'b0);
      vcount += int'(Valid);
    end
    chk("sync_no_partial", 32'(vcount), 32'd0);
    step(12'h700, 4'd1, 1'b1, 1'b0);
    chk("sync_valid", {31'd0, Valid}, 32'd1);
    chk("sync_new", out_new, 32'hFC000000);
    idle(3);

    // Mode 7 clamps to 4; R[4] is rounded up, so a constant lands a few LSBs above x<<18.
    for (int i = 0; i < 10000; i++) step(12'h900, 4'd7, 1'b1, 1'b0);
    step(12'h800, 4'd7, 1'b0, 1'b0);
    step(12'h800, 4'd7, 1'b0, 1'b0);
    chk("m7_valid", {31'd0, Valid}, 32'd1);
    chk("m7_new", out_new, 32'h04000003);
    idle(3);

    // Reset with one frame in the product stage and another partially accumulated.
    for (int i = 0; i < 11; i++) step(12'h000, 4'd1, 1'b1, 1'b0);
    do_reset(3);
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      step(12'h000, 4'd1, 1'b1, 1'b0);
      vcount += int'(Valid);
    end
    chk("no_stale_valid", 32'(vcount), 32'd0);

    // Randomized traffic with Mode wandering, occasional Sync/Enable drops and one reset.
    for (int i = 0; i < 4000; i++) begin
      int          r;
      logic [3:0]  m;
      r = int'($urandom_range(0, 99));
      if (r < 45)      m = 4'd0;
      else if (r < 85) m = 4'd1;
      else if (r < 95) m = 4'd2;
      else             m = 4'($urandom_range(3, 15));
      if (i == 2000) do_reset(2);
      step(12'($urandom_range(0, 4095)), m,
           ($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
